serial_to_parallel_flex: RTL

- Parametrised successor to the single-bit deserialiser.
- Accepts LANE_W-bit serial beats over a valid/ready handshake and assembles WIDTH-bit words.
- Per-word runtime bit order (LSB-first or MSB-first).
- Early word termination via in_last, with a count of valid bits.
- Backpressured output through an internal output slot plus one pending-word buffer, so accumulation overlaps with output stalls.
- Sits between serial link receivers and word-wide datapath consumers.

---
 rtl/s2p_pkg.sv | 18 +
 rtl/serial_to_parallel_flex_if.sv | 28 ++
 rtl/serial_to_parallel_flex_out_slot.sv | 34 +++
 rtl/serial_to_parallel_flex.sv | 113 +++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// Shared helpers for the flexible serial-to-parallel deserialiser.
package s2p_pkg;

   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   function automatic int unsigned beats(input int unsigned width, input int unsigned lane_w);
      return width / lane_w;
   endfunction

   // Low bit index of beat k inside the word; MSB-first words fill from the top down.
   function automatic int unsigned beat_off(input int unsigned k, input logic msb_first,
                                            input int unsigned width, input int unsigned lane_w);
      return msb_first ? (width - (k + 1) * lane_w) : (k * lane_w);
   endfunction

endpackage

// File: rtl/serial_to_parallel_flex_if.sv
// Serial-beat input and word output handshake bundle.
interface serial_to_parallel_flex_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned LANE_W = 1
);
   import s2p_pkg::*;

   logic                      in_valid;
   logic                      in_ready;
   logic [LANE_W-1:0]         in_data;
   logic                      in_last;
   logic                      msb_first;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          out_data;
   logic [cnt_w(WIDTH)-1:0]   out_bits;

   modport master (
      output in_valid, in_data, in_last, msb_first, out_ready,
      input  in_ready, out_valid, out_data, out_bits
   );

   modport slave (
      input  in_valid, in_data, in_last, msb_first, out_ready,
      output in_ready, out_valid, out_data, out_bits
   );

endinterface

// File: rtl/serial_to_parallel_flex_out_slot.sv
// One-entry valid/ready output register; the caller only strobes load when free is high.
module vr_out_slot #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   output logic              free,
   output logic              valid,
   input  logic              ready,
   output logic [DATA_W-1:0] data
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;

   assign free  = !valid_q || ready;
   assign valid = valid_q;
   assign data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= load_data;
      end else if (ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_to_parallel_flex.sv
// Assembles LANE_W-bit serial beats into WIDTH-bit words with per-word bit order,
// early termination and one pending word held in the accumulator under output stall.
module serial_to_parallel_flex
   import s2p_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned LANE_W = 1
) (
   input logic                     clk,
   input logic                     rst_n,
   serial_to_parallel_flex_if.slave bus
);

   localparam int unsigned Beats = beats(WIDTH, LANE_W);
   localparam int unsigned CntW  = cnt_w(WIDTH);
   localparam int unsigned KW    = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned OffW  = $clog2(WIDTH);

   if ((WIDTH % LANE_W) != 0 || WIDTH < 2) begin : g_param_check
      $error("serial_to_parallel_flex: WIDTH must be >= 2 and a multiple of LANE_W");
   end

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CntW-1:0]  acc_bits_q, acc_bits_d;
   logic [KW-1:0]    k_q, k_d;
   logic             msb_q, msb_d;
   logic             acc_full_q, acc_full_d;
   logic             in_ready_q;

   logic                  accept, done, msb_cur, slot_free, load;
   logic [OffW-1:0]       off;
   logic [WIDTH-1:0]      word;
   logic [CntW-1:0]       word_bits;
   logic [CntW+WIDTH-1:0] load_data, slot_data;

   always_comb begin
      accept    = bus.in_valid && in_ready_q;
      msb_cur   = (k_q == '0) ? bus.msb_first : msb_q;
      off       = OffW'(beat_off(32'(k_q), msb_cur, WIDTH, LANE_W));
      word      = (k_q == '0) ? '0 : acc_q;
      word[off +: LANE_W] = bus.in_data;
      word_bits = CntW'((32'(k_q) + 32'd1) * LANE_W);
      done      = accept && ((k_q == KW'(Beats - 1)) || bus.in_last);

      acc_d      = acc_q;
      acc_bits_d = acc_bits_q;
      k_d        = k_q;
      msb_d      = msb_q;
      acc_full_d = acc_full_q;
      load       = 1'b0;
      load_data  = {word_bits, word};

      if (acc_full_q) begin
         // Pending word drains into the slot; no beat is taken in this cycle.
         if (slot_free) begin
            load       = 1'b1;
            load_data  = {acc_bits_q, acc_q};
            acc_full_d = 1'b0;
         end
      end else if (accept) begin
         msb_d = msb_cur;
         if (done) begin
            k_d = '0;
            if (slot_free) begin
               load = 1'b1;
            end else begin
               acc_d      = word;
               acc_bits_d = word_bits;
               acc_full_d = 1'b1;
            end
         end else begin
            acc_d = word;
            k_d   = k_q + KW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         acc_bits_q <= '0;
         k_q        <= '0;
         msb_q      <= 1'b0;
         acc_full_q <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         acc_bits_q <= acc_bits_d;
         k_q        <= k_d;
         msb_q      <= msb_d;
         acc_full_q <= acc_full_d;
         in_ready_q <= !acc_full_d;
      end
   end

   vr_out_slot #(
      .DATA_W(CntW + WIDTH)
   ) u_out_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_data(load_data),
      .free     (slot_free),
      .valid    (bus.out_valid),
      .ready    (bus.out_ready),
      .data     (slot_data)
   );

   assign bus.in_ready = in_ready_q;
   assign bus.out_data = slot_data[WIDTH-1:0];
   assign bus.out_bits = slot_data[CntW+WIDTH-1:WIDTH];

endmodule
